distortion_sample_sequencer: RTL and testbench

Per-sample sequencer for the stereo distortion datapath. It captures one left/right sample pair and a snapshot of the gain/threshold/mode settings from the distortion controller. It then runs both channels, one after the other, through a single shared multiply/clip unit. It sits between the codec sample interface and the output mixer, and has a fixed 5-clock latency.

---
 rtl/distortion_pkg.sv | 23 ++
 rtl/distortion_clip_unit.sv | 55 +++++
 rtl/distortion_sample_sequencer.sv | 125 ++++++++++++
 tb/tb_distortion_sample_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/distortion_pkg.sv
// rtl/distortion_pkg.sv - shared types and sample limits for the distortion sequencer
package distortion_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS    = 2'd0,
        MODE_GAIN      = 2'd1,
        MODE_CLIP      = 2'd2,
        MODE_GAIN_CLIP = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL_L  = 3'd1,
        S_CLIP_L = 3'd2,
        S_MUL_R  = 3'd3,
        S_CLIP_R = 3'd4,
        S_DONE   = 3'd5
    } seq_state_t;

    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;

endpackage

// File: rtl/distortion_clip_unit.sv
// rtl/distortion_clip_unit.sv - combinational clip/saturate stage shared by both channels
module distortion_clip_unit
    import distortion_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PROD_W = 32,
    parameter int THR_W  = 32
) (
    input  mode_t                     mode,
    input  logic signed [DATA_W-1:0]  sample,
    input  logic signed [PROD_W-1:0]  product,
    input  logic signed [THR_W-1:0]   threshold,
    output logic signed [DATA_W-1:0]  result
);

    // One spare bit so that negating the threshold can never overflow.
    localparam int CW = ((PROD_W > THR_W) ? PROD_W : THR_W) + 1;

    localparam logic signed [CW-1:0] SMAX = {{(CW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [CW-1:0] SMIN = {{(CW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [CW-1:0] sample_ext;
    logic signed [CW-1:0] product_ext;
    logic signed [CW-1:0] thr_eff;
    logic signed [CW-1:0] neg_thr;
    logic signed [CW-1:0] v;
    logic signed [CW-1:0] clipped;
    logic signed [CW-1:0] sat_v;

    always_comb begin
        sample_ext  = {{(CW-DATA_W){sample[DATA_W-1]}}, sample};
        product_ext = {{(CW-PROD_W){product[PROD_W-1]}}, product};
        thr_eff     = threshold[THR_W-1] ? '0 : {{(CW-THR_W){1'b0}}, threshold};
        neg_thr     = -thr_eff;

        v = mode[0] ? product_ext : sample_ext;

        clipped = v;
        if (mode[1]) begin
            if (v > thr_eff)
                clipped = thr_eff;
            else if (v < neg_thr)
                clipped = neg_thr;
        end

        sat_v = clipped;
        if (clipped > SMAX)
            sat_v = SMAX;
        else if (clipped < SMIN)
            sat_v = SMIN;

        result = (mode == MODE_BYPASS) ? sample : sat_v[DATA_W-1:0];
    end

endmodule

// File: rtl/distortion_sample_sequencer.sv
// rtl/distortion_sample_sequencer.sv - stereo sample sequencer sharing one multiply/clip unit
module distortion_sample_sequencer
    import distortion_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int THR_W  = 32,
    parameter int OVR_W  = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  in_l,
    input  logic signed [DATA_W-1:0]  in_r,
    input  logic signed [GAIN_W-1:0]  gain,
    input  logic signed [THR_W-1:0]   threshold,
    input  logic        [1:0]         mode,
    input  logic                      overrun_clr,
    output logic                      out_valid,
    output logic signed [DATA_W-1:0]  out_l,
    output logic signed [DATA_W-1:0]  out_r,
    output logic                      busy,
    output logic        [OVR_W-1:0]   overrun_cnt
);

    localparam int PROD_W = DATA_W + GAIN_W;

    seq_state_t state, next_state;

    logic signed [DATA_W-1:0] l_s, r_s;
    logic signed [GAIN_W-1:0] gain_s;
    logic signed [THR_W-1:0]  thr_s;
    mode_t                    mode_s;
    logic signed [PROD_W-1:0] product;
    logic signed [DATA_W-1:0] result_l, result_r;

    logic                     chan_r;
    logic signed [DATA_W-1:0] sample_sel;
    logic signed [PROD_W-1:0] mul_full;
    logic signed [DATA_W-1:0] clip_result;
    logic                     drop;

    // Right channel owns the shared datapath during its MUL/CLIP pair.
    assign chan_r     = (state == S_MUL_R) || (state == S_CLIP_R);
    assign sample_sel = chan_r ? r_s : l_s;
    assign mul_full   = PROD_W'(sample_sel) * PROD_W'(gain_s);
    assign drop       = in_valid && (state != S_IDLE);

    distortion_clip_unit #(
        .DATA_W (DATA_W),
        .PROD_W (PROD_W),
        .THR_W  (THR_W)
    ) u_clip (
        .mode      (mode_s),
        .sample    (sample_sel),
        .product   (product),
        .threshold (thr_s),
        .result    (clip_result)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (in_valid) next_state = S_MUL_L;
            S_MUL_L:  next_state = S_CLIP_L;
            S_CLIP_L: next_state = S_MUL_R;
            S_MUL_R:  next_state = S_CLIP_R;
            S_CLIP_R: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            l_s         <= '0;
            r_s         <= '0;
            gain_s      <= '0;
            thr_s       <= '0;
            mode_s      <= MODE_BYPASS;
            product     <= '0;
            result_l    <= '0;
            result_r    <= '0;
            out_valid   <= 1'b0;
            out_l       <= '0;
            out_r       <= '0;
            overrun_cnt <= '0;
        end else begin
            out_valid <= (state == S_DONE);
            case (state)
                S_IDLE: if (in_valid) begin
                    l_s    <= in_l;
                    r_s    <= in_r;
                    gain_s <= gain;
                    thr_s  <= threshold;
                    mode_s <= mode_t'(mode);
                end
                S_MUL_L, S_MUL_R: product  <= mul_full;
                S_CLIP_L:         result_l <= clip_result;
                S_CLIP_R:         result_r <= clip_result;
                S_DONE: begin
                    out_l <= result_l;
                    out_r <= result_r;
                end
                default: ;
            endcase
            // Clear takes priority over a coincident drop.
            if (overrun_clr)
                overrun_cnt <= '0;
            else if (drop && (overrun_cnt != '1))
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_distortion_sample_sequencer.sv
// tb/tb_distortion_sample_sequencer.sv - directed self-checking bench for distortion_sample_sequencer
module tb_distortion_sample_sequencer;
    import distortion_pkg::*;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_l = '0;
    logic signed [15:0] in_r = '0;
    logic signed [15:0] gain = '0;
    logic signed [31:0] threshold = '0;
    logic        [1:0]  mode = '0;
    logic               overrun_clr = 1'b0;
    logic               out_valid;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic               busy;
    logic        [7:0]  overrun_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    distortion_sample_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_l        (in_l),
        .in_r        (in_r),
        .gain        (gain),
        .threshold   (threshold),
        .mode        (mode),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .out_l       (out_l),
        .out_r       (out_r),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 CLK = ~CLK;

    // Capture one pair, optionally change threshold right after capture, and
    // watch 9 further edges for the out_valid pulse.
    task automatic run_pair(input logic signed [15:0] l, input logic signed [15:0] r,
                            input logic signed [15:0] g, input logic signed [31:0] t,
                            input logic signed [31:0] t_after, input logic [1:0] m,
                            output int first_e, output int pulses,
                            output logic b0, output logic b5);
        @(negedge CLK);
        in_l = l; in_r = r; gain = g; threshold = t; mode = m; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        threshold = t_after;
        b0 = busy;
        b5 = 1'b1;
        first_e = -1;
        pulses = 0;
        for (int e = 1; e <= 9; e++) begin
            @(negedge CLK);
            if (out_valid) begin
                pulses++;
                if (first_e < 0) first_e = e;
            end
            if (e == 5) b5 = busy;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_l !== 16'sd0) $display("FAIL reset_out_l: got %0d expected 0", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== 16'sd0) $display("FAIL reset_out_r: got %0d expected 0", out_r); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
        total_cnt++; if (overrun_cnt !== 8'd0) $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt); else pass_cnt++;
    endtask

    task automatic test_bypass();
        int fe, np; logic b0, b5;
        run_pair(16'sd1234, -16'sd5678, 16'sd7, 32'sd10, 32'sd10, 2'd0, fe, np, b0, b5);
        total_cnt++; if (fe !== 5) $display("FAIL bypass_latency: got %0d expected 5", fe); else pass_cnt++;
        total_cnt++; if (np !== 1) $display("FAIL bypass_pulses: got %0d expected 1", np); else pass_cnt++;
        total_cnt++; if (b0 !== 1'b1) $display("FAIL bypass_busy_after_capture: got %0b expected 1", b0); else pass_cnt++;
        total_cnt++; if (b5 !== 1'b0) $display("FAIL bypass_busy_after_done: got %0b expected 0", b5); else pass_cnt++;
        total_cnt++; if (out_l !== 16'sd1234) $display("FAIL bypass_out_l: got %0d expected 1234", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== -16'sd5678) $display("FAIL bypass_out_r: got %0d expected -5678", out_r); else pass_cnt++;
    endtask

    task automatic test_gain();
        int fe, np; logic b0, b5;
        run_pair(16'sd1000, -16'sd1000, 16'sd50, 32'sd0, 32'sd0, 2'd1, fe, np, b0, b5);
        total_cnt++; if (out_l !== 16'(SAMPLE_MAX)) $display("FAIL gain_sat_l: got %0d expected 32767", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== 16'(SAMPLE_MIN)) $display("FAIL gain_sat_r: got %0d expected -32768", out_r); else pass_cnt++;
        run_pair(16'sd100, -16'sd7, 16'sd3, 32'sd0, 32'sd0, 2'd1, fe, np, b0, b5);
        total_cnt++; if (out_l !== 16'sd300) $display("FAIL gain3_l: got %0d expected 300", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== -16'sd21) $display("FAIL gain3_r: got %0d expected -21", out_r); else pass_cnt++;
        run_pair(16'sd100, -16'sd7, -16'sd2, 32'sd0, 32'sd0, 2'd1, fe, np, b0, b5);
        total_cnt++; if (out_l !== -16'sd200) $display("FAIL gain_neg_l: got %0d expected -200", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== 16'sd14) $display("FAIL gain_neg_r: got %0d expected 14", out_r); else pass_cnt++;
    endtask

    task automatic test_gain_clip_change();
        int fe, np; logic b0, b5;
        run_pair(16'sd50, -16'sd200, 16'sd10, 32'sd1000, 32'sd20, 2'd3, fe, np, b0, b5);
        total_cnt++; if (out_l !== 16'sd500) $display("FAIL gclip_l: got %0d expected 500", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== -16'sd1000) $display("FAIL gclip_r: got %0d expected -1000", out_r); else pass_cnt++;
    endtask

    task automatic test_clip_edges();
        int fe, np; logic b0, b5;
        run_pair(16'sd300, -16'sd300, 16'sd9, 32'sd100, 32'sd100, 2'd2, fe, np, b0, b5);
        total_cnt++; if (out_l !== 16'sd100) $display("FAIL clip100_l: got %0d expected 100", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== -16'sd100) $display("FAIL clip100_r: got %0d expected -100", out_r); else pass_cnt++;
        run_pair(16'sd500, -16'sd500, 16'sd9, -32'sd5, -32'sd5, 2'd2, fe, np, b0, b5);
        total_cnt++; if (out_l !== 16'sd0) $display("FAIL clipneg_l: got %0d expected 0", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== 16'sd0) $display("FAIL clipneg_r: got %0d expected 0", out_r); else pass_cnt++;
        run_pair(-16'sd32768, 16'sd12345, 16'sd9, 32'sd40000, 32'sd40000, 2'd2, fe, np, b0, b5);
        total_cnt++; if (out_l !== -16'sd32768) $display("FAIL cliphigh_l: got %0d expected -32768", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== 16'sd12345) $display("FAIL cliphigh_r: got %0d expected 12345", out_r); else pass_cnt++;
        run_pair(16'sd500, -16'sd500, 16'sd9, 32'sd0, 32'sd0, 2'd2, fe, np, b0, b5);
        total_cnt++; if (out_l !== 16'sd0) $display("FAIL clipzero_l: got %0d expected 0", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== 16'sd0) $display("FAIL clipzero_r: got %0d expected 0", out_r); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int np = 0;
        @(negedge CLK);
        in_l = 16'sd11; in_r = 16'sd22; mode = 2'd0; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge CLK);
            if (out_valid) np++;
            in_valid = (e == 1) || (e == 2) || (e == 4);
        end
        in_valid = 1'b0;
        total_cnt++; if (overrun_cnt !== 8'd3) $display("FAIL overrun_three: got %0d expected 3", overrun_cnt); else pass_cnt++;
        total_cnt++; if (np !== 1) $display("FAIL overrun_pulses: got %0d expected 1", np); else pass_cnt++;
        total_cnt++; if (out_l !== 16'sd11) $display("FAIL overrun_out_l: got %0d expected 11", out_l); else pass_cnt++;
    endtask

    task automatic test_saturate();
        @(negedge CLK);
        in_valid = 1'b1;
        repeat (420) @(negedge CLK);
        in_valid = 1'b0;
        repeat (10) @(negedge CLK);
        total_cnt++; if (overrun_cnt !== 8'd255) $display("FAIL overrun_saturate: got %0d expected 255", overrun_cnt); else pass_cnt++;
    endtask

    task automatic test_clear();
        @(negedge CLK);
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b1; overrun_clr = 1'b1;
        @(negedge CLK);
        overrun_clr = 1'b0;
        total_cnt++; if (overrun_cnt !== 8'd0) $display("FAIL clear_with_drop: got %0d expected 0", overrun_cnt); else pass_cnt++;
        @(negedge CLK);
        in_valid = 1'b0;
        total_cnt++; if (overrun_cnt !== 8'd1) $display("FAIL drop_after_clear: got %0d expected 1", overrun_cnt); else pass_cnt++;
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_mid_reset();
        int np = 0;
        @(negedge CLK);
        in_l = 16'sd111; in_r = 16'sd222; mode = 2'd0; in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0b expected 0", busy); else pass_cnt++;
        total_cnt++; if (out_l !== 16'sd0) $display("FAIL midrst_out_l: got %0d expected 0", out_l); else pass_cnt++;
        total_cnt++; if (out_r !== 16'sd0) $display("FAIL midrst_out_r: got %0d expected 0", out_r); else pass_cnt++;
        total_cnt++; if (overrun_cnt !== 8'd0) $display("FAIL midrst_overrun: got %0d expected 0", overrun_cnt); else pass_cnt++;
        @(negedge CLK);
        RST = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(negedge CLK);
            if (out_valid) np++;
        end
        total_cnt++; if (np !== 0) $display("FAIL midrst_no_pulse: got %0d expected 0", np); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_idle: got %0b expected 0", busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_gain();
        test_gain_clip_change();
        test_clip_edges();
        test_overrun();
        test_saturate();
        test_clear();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
